// File: rtl/serial_deserializer_pkg.sv
// ============================================================================
// serial_deserializer_pkg : shared types, defaults and counter-width helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_deserializer_pkg;

  localparam int PKT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_e;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_deserializer_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, push and pop may coincide even when full
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_out = mem_q[rd_q[AW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = data_in;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_deserializer.sv
// ============================================================================
// serial_deserializer : start/stop framed serial receiver feeding a pop FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int PKT_W        = PKT_W_DEF,
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_sIn,
  input  logic             io_rdEn,
  output logic             io_dataReady,
  output logic [PKT_W-1:0] io_pOut,
  output logic             io_validOut
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(PKT_W);
  localparam logic [CW-1:0] C_MID      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(PKT_W - 1);

  rx_state_e        state_q, state_d;
  logic             sin_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             start_q, start_d;
  logic [PKT_W-1:0] shift_q, shift_d;
  logic [PKT_W-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;

  logic             frame_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PKT_W-1:0] fifo_dout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    start_d   = start_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;
    case (state_q)
      IDLE: begin
        // A falling edge starts a mid-bit countdown; the start bit must still be low there.
        if (start_q || !sin_q) begin
          if (cnt_q == C_MID) begin
            cnt_d   = '0;
            start_d = 1'b0;
            if (!sin_q) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end else begin
            cnt_d   = cnt_q + CW'(1);
            start_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[PKT_W-2:0], sin_q};
          if (bit_cnt_q == C_BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d    = '0;
          state_d  = IDLE;
          frame_ok = sin_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        start_d = 1'b0;
      end
    endcase
  end

  assign fifo_pop  = io_rdEn && !fifo_empty;
  assign fifo_push = frame_ok && (!fifo_full || fifo_pop);

  always_comb begin
    pout_d  = fifo_pop ? fifo_dout : pout_q;
    valid_d = fifo_pop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sin_q     <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      start_q   <= 1'b0;
      shift_q   <= '0;
      pout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sin_q     <= io_sIn;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      start_q   <= start_d;
      shift_q   <= shift_d;
      pout_q    <= pout_d;
      valid_q   <= valid_d;
    end
  end

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .data_in  (shift_q),
    .pop      (fifo_pop),
    .data_out (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign io_dataReady = !fifo_empty;
  assign io_pOut      = pout_q;
  assign io_validOut  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// ============================================================================
// tb_serial_deserializer : scoreboard bench for serial_deserializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_deserializer;

  localparam int PKT_W = 8;
  localparam int CPB   = 1;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_sIn = 1'b1;
  logic             io_rdEn = 1'b0;
  logic             io_dataReady;
  logic [PKT_W-1:0] io_pOut;
  logic             io_validOut;

  int               n_checks = 0;
  int               n_fail = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] mon_exp;
  logic [PKT_W-1:0] rnd;
  bit               auto_pop = 1'b0;
  bit               manual_rd = 1'b0;

  serial_deserializer #(
    .PKT_W        (PKT_W),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_sIn       (io_sIn),
    .io_rdEn      (io_rdEn),
    .io_dataReady (io_dataReady),
    .io_pOut      (io_pOut),
    .io_validOut  (io_validOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < CPB; i++) begin
      @(posedge clock);
      #1;
      io_sIn = b;
    end
  endtask

  task automatic send_frame(input logic [PKT_W-1:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = PKT_W - 1; i >= 0; i--) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100 && !io_dataReady; i++) @(negedge clock);
    check(name, {31'd0, io_dataReady}, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, exp_q.size(), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  // Consumer: one driver for io_rdEn, updated just after each rising edge.
  always @(posedge clock) begin
    #2;
    io_rdEn = manual_rd | (auto_pop & io_dataReady);
  end

  // Monitor: every valid pulse must match the next expected word.
  always @(negedge clock) begin
    if (reset && io_validOut) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got pOut=%0h, required no output", io_pOut);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pout_data", {24'd0, io_pOut}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pout", {24'd0, io_pOut}, 32'd0);
    check("rst_valid", {31'd0, io_validOut}, 32'd0);
    check("rst_ready", {31'd0, io_dataReady}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Pop while empty: no valid pulse, pOut unchanged
    manual_rd = 1'b1;
    repeat (4) @(posedge clock);
    #1 manual_rd = 1'b0;
    repeat (2) @(negedge clock);
    check("empty_pop_pout", {24'd0, io_pOut}, 32'd0);
    check("empty_pop_ready", {31'd0, io_dataReady}, 32'd0);

    // Single frame 0xA5, one-cycle pop
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    wait_ready("a5_ready");
    @(posedge clock);
    #1 manual_rd = 1'b1;
    @(posedge clock);
    #1 manual_rd = 1'b0;
    repeat (2) @(negedge clock);
    check("a5_delivered", exp_q.size(), 32'd0);
    check("a5_ready_fall", {31'd0, io_dataReady}, 32'd0);
    check("a5_pout_hold", {24'd0, io_pOut}, 32'hA5);

    // Overflow: five frames, fifth dropped
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) exp_q.push_back(PKT_W'(i));
      send_frame(PKT_W'(i), 1'b1);
    end
    idle_bits(3);
    check("ovf_ready", {31'd0, io_dataReady}, 32'd1);
    auto_pop = 1'b1;
    drain("ovf_drain");
    auto_pop = 1'b0;
    check("ovf_ready_fall", {31'd0, io_dataReady}, 32'd0);

    // Framing error then a valid frame
    send_frame(8'h3C, 1'b0);
    idle_bits(4);
    check("ferr_no_push", {31'd0, io_dataReady}, 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    wait_ready("ferr_next_ready");
    auto_pop = 1'b1;
    drain("ferr_drain");

    // 100 back-to-back random frames with a live consumer
    for (int i = 0; i < 100; i++) begin
      rnd = PKT_W'($urandom);
      exp_q.push_back(rnd);
      send_frame(rnd, 1'b1);
    end
    idle_bits(2);
    drain("rand_drain");
    auto_pop = 1'b0;
    check("rand_pout_last", {24'd0, io_pOut}, {24'd0, rnd});

    // Reset midway through 0xFF, then 0x12
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_pout", {24'd0, io_pOut}, 32'd0);
    check("midrst_valid", {31'd0, io_validOut}, 32'd0);
    check("midrst_ready", {31'd0, io_dataReady}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    idle_bits(2);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle_bits(1);
    wait_ready("post_rst_ready");
    auto_pop = 1'b1;
    drain("post_rst_drain");
    auto_pop = 1'b0;
    check("post_rst_pout", {24'd0, io_pOut}, 32'h12);
    check("final_ready", {31'd0, io_dataReady}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
